// File: rtl/imem_fetch_resp_if.sv
// Fetch-side bus between the PC unit (master) and the instruction-memory responder (slave),
// including the program-load write port.
interface imem_fetch_resp_if;
    logic        req;
    logic [15:0] addr;
    logic        flush;
    logic        wr_en;
    logic [15:0] wr_addr;
    logic [15:0] wr_data;
    logic [15:0] inst;
    logic        done;
    logic        stall;
    logic        err;

    modport master (
        output req, addr, flush, wr_en, wr_addr, wr_data,
        input  inst, done, stall, err
    );

    modport slave (
        input  req, addr, flush, wr_en, wr_addr, wr_data,
        output inst, done, stall, err
    );
endinterface

// File: rtl/imem_fetch_resp.sv
// Instruction-memory fetch responder: fixed-latency word fetch with stall and flush.
// Optional misaligned-fetch detection is enabled by defining IMEM_ALIGN_CHK_EN.
module imem_fetch_resp #(
    parameter int LATENCY = 2,
    parameter int MEM_AW  = 10
) (
    input  logic             clk,
    input  logic             rst,
    imem_fetch_resp_if.slave bus
);
    localparam logic [15:0] NOP_INST = 16'h0800;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t            state_reg;
    state_t            state_next;
    logic [3:0]        cnt_reg;
    logic [3:0]        cnt_next;
    logic [MEM_AW:0]   addr_q_reg;
    logic [MEM_AW:0]   addr_q_next;
    logic [15:0]       inst_reg;
    logic              done_reg;
    logic              err_reg;
    logic              accept;
    logic              rsp_fire;
    logic              misaligned;
    logic [MEM_AW:0]   resp_addr;
    logic [MEM_AW-1:0] rd_idx;

    logic [15:0] mem [0:(2**MEM_AW)-1];

    // With single-cycle latency the response is produced on the acceptance edge,
    // so the word address comes straight from the request rather than addr_q.
    generate
        if (LATENCY == 1) begin : g_direct
            assign resp_addr = bus.addr[MEM_AW:0];
        end else begin : g_reg
            assign resp_addr = addr_q_reg;
        end
    endgenerate

    assign rd_idx = resp_addr[MEM_AW:1];

`ifdef IMEM_ALIGN_CHK_EN
    assign misaligned = resp_addr[0];
`else
    assign misaligned = 1'b0;
`endif

    assign accept = (state_reg == IDLE) && bus.req && !bus.flush;

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        addr_q_next = addr_q_reg;
        rsp_fire    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    addr_q_next = bus.addr[MEM_AW:0];
                    cnt_next    = 4'(LATENCY - 1);
                    if (LATENCY > 1) begin
                        state_next = BUSY;
                    end else begin
                        rsp_fire = 1'b1;
                    end
                end
            end
            BUSY: begin
                // A redirect drops the fetch silently: no done, no err, inst untouched.
                if (bus.flush) begin
                    state_next = IDLE;
                    cnt_next   = 4'd0;
                end else begin
                    cnt_next = cnt_reg - 4'd1;
                    if (cnt_reg == 4'd1) begin
                        rsp_fire   = 1'b1;
                        state_next = IDLE;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            cnt_reg    <= 4'd0;
            addr_q_reg <= '0;
            inst_reg   <= 16'h0000;
            done_reg   <= 1'b0;
            err_reg    <= 1'b0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            addr_q_reg <= addr_q_next;
            done_reg   <= rsp_fire;
            err_reg    <= rsp_fire && misaligned;
            if (rsp_fire) begin
                inst_reg <= misaligned ? NOP_INST : mem[rd_idx];
            end
        end
    end

    // Program-load port; a same-edge read of this word sees the previous contents.
    always_ff @(posedge clk) begin
        if (bus.wr_en) begin
            mem[bus.wr_addr[MEM_AW:1]] <= bus.wr_data;
        end
    end

    assign bus.inst  = inst_reg;
    assign bus.done  = done_reg;
    assign bus.err   = err_reg;
    assign bus.stall = (state_reg == BUSY) || accept;

    // Address bits above the memory size wrap; bit 0 only matters with alignment checking.
    logic unused_bits;
    assign unused_bits = ^{bus.addr, bus.wr_addr, addr_q_reg, resp_addr};
endmodule

// File: tb/tb_imem_fetch_resp.sv
// Scoreboard bench for imem_fetch_resp: one LATENCY=2 instance and one LATENCY=1 instance.
module tb_imem_fetch_resp;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    imem_fetch_resp_if bus_a ();
    imem_fetch_resp_if bus_b ();

    imem_fetch_resp #(.LATENCY(2), .MEM_AW(10)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
    imem_fetch_resp #(.LATENCY(1), .MEM_AW(10)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

    typedef struct {
        logic [15:0] inst;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    int   cyc    = 0;
    int   errors = 0;
    int   checks = 0;

`ifdef IMEM_ALIGN_CHK_EN
    localparam logic [15:0] MIS_INST = 16'h0800;
    localparam logic        MIS_ERR  = 1'b1;
`else
    localparam logic [15:0] MIS_INST = 16'hC123;
    localparam logic        MIS_ERR  = 1'b0;
`endif

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input logic r, input logic [15:0] a, input logic f);
        bus_a.req = r; bus_a.addr = a; bus_a.flush = f;
    endtask

    task automatic drive_b(input logic r, input logic [15:0] a, input logic f);
        bus_b.req = r; bus_b.addr = a; bus_b.flush = f;
    endtask

    task automatic wr_a(input logic [15:0] a, input logic [15:0] d);
        bus_a.wr_en = 1'b1; bus_a.wr_addr = a; bus_a.wr_data = d;
        step();
        bus_a.wr_en = 1'b0;
    endtask

    task automatic wr_b(input logic [15:0] a, input logic [15:0] d);
        bus_b.wr_en = 1'b1; bus_b.wr_addr = a; bus_b.wr_data = d;
        step();
        bus_b.wr_en = 1'b0;
    endtask

    // Monitors: retire expected responses whenever done is seen, flag missing/extra ones.
    always @(negedge clk) begin : mon_a
        exp_t e;
        while (q_a.size() > 0 && q_a[0].cyc < cyc) begin
            checks++; errors++;
            $display("FAIL a_missing_done: no done seen, required done at cycle %0d with inst %h", q_a[0].cyc, q_a[0].inst);
            void'(q_a.pop_front());
        end
        if (bus_a.done) begin
            if (q_a.size() == 0) begin
                checks++; errors++;
                $display("FAIL a_unexpected_done: done=1 inst=%h at cycle %0d, required done=0", bus_a.inst, cyc);
            end else begin
                e = q_a.pop_front();
                chk("a_done_cycle", cyc, e.cyc);
                chk("a_inst", bus_a.inst, e.inst);
                chk("a_err", bus_a.err, e.err);
            end
        end
    end

    always @(negedge clk) begin : mon_b
        exp_t e;
        while (q_b.size() > 0 && q_b[0].cyc < cyc) begin
            checks++; errors++;
            $display("FAIL b_missing_done: no done seen, required done at cycle %0d with inst %h", q_b[0].cyc, q_b[0].inst);
            void'(q_b.pop_front());
        end
        if (bus_b.done) begin
            if (q_b.size() == 0) begin
                checks++; errors++;
                $display("FAIL b_unexpected_done: done=1 inst=%h at cycle %0d, required done=0", bus_b.inst, cyc);
            end else begin
                e = q_b.pop_front();
                chk("b_done_cycle", cyc, e.cyc);
                chk("b_inst", bus_b.inst, e.inst);
                chk("b_err", bus_b.err, e.err);
            end
        end
    end

    initial begin
        rst = 1'b1;
        drive_a(1'b0, 16'h0000, 1'b0);
        drive_b(1'b0, 16'h0000, 1'b0);
        bus_a.wr_en = 1'b0; bus_a.wr_addr = '0; bus_a.wr_data = '0;
        bus_b.wr_en = 1'b0; bus_b.wr_addr = '0; bus_b.wr_data = '0;
        step();
        step();
        chk("rst_inst", bus_a.inst, 16'h0000);
        chk("rst_done", bus_a.done, 1'b0);
        chk("rst_err", bus_a.err, 1'b0);
        chk("rst_stall", bus_a.stall, 1'b0);
        $display("reset released at cycle %0d", cyc);
        rst = 1'b0;

        wr_a(16'h0020, 16'hC123);
        wr_a(16'h0022, 16'h4444);
        wr_a(16'h0040, 16'h2222);
        wr_a(16'h0042, 16'h3333);
        wr_b(16'h0000, 16'hABCD);
        wr_b(16'h0002, 16'h5A5A);
        $display("program load done at cycle %0d", cyc);

        // Basic fetch, with a second request held through the first done cycle.
        drive_a(1'b1, 16'h0020, 1'b0);
        q_a.push_back('{16'hC123, 1'b0, cyc + 2});
        #1 chk("stall_accept", bus_a.stall, 1'b1);
        $display("fetch addr=0020 issued at cycle %0d", cyc);
        step();
        drive_a(1'b1, 16'h0022, 1'b0);
        #1 chk("stall_busy", bus_a.stall, 1'b1);
        step();
        q_a.push_back('{16'h4444, 1'b0, cyc + 2});
        #1 chk("stall_b2b_accept", bus_a.stall, 1'b1);
        $display("fetch addr=0022 accepted in done cycle %0d", cyc);
        step();
        drive_a(1'b0, 16'h0000, 1'b0);
        #1 chk("stall_busy2", bus_a.stall, 1'b1);
        step();
        #1 chk("stall_done_idle", bus_a.stall, 1'b0);
        step();

        // Flush cancels the in-flight fetch; the next request completes normally.
        drive_a(1'b1, 16'h0040, 1'b0);
        $display("fetch addr=0040 issued at cycle %0d (to be flushed)", cyc);
        step();
        drive_a(1'b0, 16'h0000, 1'b1);
        #1 chk("stall_flush_busy", bus_a.stall, 1'b1);
        step();
        drive_a(1'b1, 16'h0042, 1'b0);
        #1 chk("inst_kept_after_flush", bus_a.inst, 16'h4444);
        chk("stall_after_flush", bus_a.stall, 1'b1);
        q_a.push_back('{16'h3333, 1'b0, cyc + 2});
        $display("fetch addr=0042 issued at cycle %0d", cyc);
        step();
        drive_a(1'b0, 16'h0000, 1'b0);
        step();
        step();

        // Flush together with a request in IDLE: not accepted, re-presented next cycle.
        drive_a(1'b1, 16'h0020, 1'b1);
        #1 chk("stall_req_flush_idle", bus_a.stall, 1'b0);
        step();
        drive_a(1'b1, 16'h0020, 1'b0);
        q_a.push_back('{16'hC123, 1'b0, cyc + 2});
        $display("fetch addr=0020 re-presented at cycle %0d", cyc);
        step();
        drive_a(1'b0, 16'h0000, 1'b0);
        step();
        step();

        // Misaligned fetch.
        drive_a(1'b1, 16'h0021, 1'b0);
        q_a.push_back('{MIS_INST, MIS_ERR, cyc + 2});
        $display("fetch addr=0021 issued at cycle %0d", cyc);
        step();
        drive_a(1'b0, 16'h0000, 1'b0);
        step();
        step();

        // Reset mid-fetch aborts it; memory survives.
        drive_a(1'b1, 16'h0020, 1'b0);
        step();
        drive_a(1'b0, 16'h0000, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1 chk("rst_mid_inst", bus_a.inst, 16'h0000);
        chk("rst_mid_done", bus_a.done, 1'b0);
        chk("rst_mid_err", bus_a.err, 1'b0);
        $display("reset mid-fetch completed at cycle %0d", cyc);
        drive_a(1'b1, 16'h0020, 1'b0);
        q_a.push_back('{16'hC123, 1'b0, cyc + 2});
        step();
        drive_a(1'b0, 16'h0000, 1'b0);
        step();
        step();

        // LATENCY=1 instance: wrap-around addressing, back-to-back, same-edge write.
        drive_b(1'b1, 16'h0800, 1'b0);
        q_b.push_back('{16'hABCD, 1'b0, cyc + 1});
        #1 chk("b_stall_accept", bus_b.stall, 1'b1);
        $display("L1 fetch addr=0800 issued at cycle %0d", cyc);
        step();
        drive_b(1'b1, 16'h0802, 1'b0);
        q_b.push_back('{16'h5A5A, 1'b0, cyc + 1});
        #1 chk("b_stall_b2b", bus_b.stall, 1'b1);
        step();
        drive_b(1'b0, 16'h0000, 1'b0);
        #1 chk("b_stall_idle", bus_b.stall, 1'b0);
        step();
        drive_b(1'b1, 16'h0800, 1'b0);
        bus_b.wr_en = 1'b1; bus_b.wr_addr = 16'h0000; bus_b.wr_data = 16'hFFFF;
        q_b.push_back('{16'hABCD, 1'b0, cyc + 1});
        $display("L1 fetch+write same word at cycle %0d", cyc);
        step();
        bus_b.wr_en = 1'b0;
        q_b.push_back('{16'hFFFF, 1'b0, cyc + 1});
        step();
        drive_b(1'b0, 16'h0000, 1'b0);
        step();

        for (int i = 0; i < 20 && (q_a.size() > 0 || q_b.size() > 0); i++) step();
        if (q_a.size() > 0 || q_b.size() > 0) begin
            checks++; errors++;
            $display("FAIL drain_timeout: %0d/%0d responses outstanding, required 0", q_a.size(), q_b.size());
        end
        step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
